// File: rtl/aes_batch_ctrl.sv
// Batch sequencer between usb_reg and aes_core: runs N back-to-back AES-128
// encryptions per start, advancing the plaintext in fixed, chained or incrementing mode.
module aes_batch_ctrl #(
    parameter int pDATA_WIDTH  = 128,
    parameter int pCOUNT_WIDTH = 16,
    parameter int pGAP_WIDTH   = 8,
    parameter int pTIMEOUT     = 64
) (
    input  logic                    dut_clk,
    input  logic                    dut_rst,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [1:0]              mode_i,
    input  logic [pCOUNT_WIDTH-1:0] count_i,
    input  logic [pGAP_WIDTH-1:0]   gap_i,
    input  logic [pDATA_WIDTH-1:0]  key_i,
    input  logic [pDATA_WIDTH-1:0]  pt_i,
    output logic                    aes_load_o,
    output logic [pDATA_WIDTH-1:0]  aes_key_o,
    output logic [pDATA_WIDTH-1:0]  aes_data_o,
    input  logic                    aes_busy_i,
    input  logic [pDATA_WIDTH-1:0]  aes_data_i,
    output logic                    trigger_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [pDATA_WIDTH-1:0]  ct_o,
    output logic [pCOUNT_WIDTH-1:0] iter_o
);
    localparam int lTMO_WIDTH = $clog2(pTIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        RUN,
        GAP,
        FINISH
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [1:0]              r_mode;
    logic [pCOUNT_WIDTH-1:0] r_count;
    logic [pCOUNT_WIDTH-1:0] r_iter;
    logic [pGAP_WIDTH-1:0]   r_gap;
    logic [pGAP_WIDTH-1:0]   r_gapCnt;
    logic [lTMO_WIDTH-1:0]   r_tmo;
    logic [pDATA_WIDTH-1:0]  r_key;
    logic [pDATA_WIDTH-1:0]  r_data;
    logic [pDATA_WIDTH-1:0]  r_ct;
    logic                    r_error;

    logic                    w_abort;
    logic                    w_start;
    logic                    w_coreDone;
    logic                    w_timeout;
    logic                    w_lastIter;
    logic                    w_gapDone;
    logic [pCOUNT_WIDTH-1:0] w_iterNext;

    // Abort only acts on a running batch; in IDLE it also suppresses a coincident start.
    assign w_abort    = abort_i && (r_state != IDLE);
    assign w_start    = start_i && !abort_i && (r_state == IDLE);
    assign w_coreDone = (r_state == RUN) && !aes_busy_i;
    assign w_timeout  = (r_state == WAIT_BUSY) && !aes_busy_i &&
                        (r_tmo == lTMO_WIDTH'(pTIMEOUT - 1));
    assign w_iterNext = r_iter + 1'b1;
    assign w_lastIter = (w_iterNext == r_count);
    assign w_gapDone  = (r_gapCnt == r_gap - pGAP_WIDTH'(1));

    always_ff @(posedge dut_clk) begin
        if (dut_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        w_next = (count_i == '0) ? FINISH : LOAD;
                    end
                end
                LOAD: w_next = WAIT_BUSY;
                WAIT_BUSY: begin
                    if (aes_busy_i) begin
                        w_next = RUN;
                    end else if (w_timeout) begin
                        w_next = FINISH;
                    end
                end
                RUN: begin
                    if (!aes_busy_i) begin
                        if (w_lastIter) begin
                            w_next = FINISH;
                        end else if (r_gap == '0) begin
                            w_next = LOAD;
                        end else begin
                            w_next = GAP;
                        end
                    end
                end
                GAP: begin
                    if (w_gapDone) begin
                        w_next = LOAD;
                    end
                end
                FINISH:  w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        aes_load_o = 1'b0;
        trigger_o  = 1'b0;
        done_o     = 1'b0;
        busy_o     = (r_state != IDLE);
        case (r_state)
            LOAD: begin
                aes_load_o = 1'b1;
                trigger_o  = 1'b1;
            end
            WAIT_BUSY: trigger_o = 1'b1;
            RUN:       trigger_o = 1'b1;
            FINISH:    done_o    = 1'b1;
            default: ;
        endcase
    end

    // Batch parameters are frozen at start so later input changes cannot disturb the run.
    always_ff @(posedge dut_clk) begin
        if (dut_rst) begin
            r_mode   <= '0;
            r_count  <= '0;
            r_iter   <= '0;
            r_gap    <= '0;
            r_gapCnt <= '0;
            r_tmo    <= '0;
            r_key    <= '0;
            r_data   <= '0;
            r_ct     <= '0;
            r_error  <= 1'b0;
        end else if (w_start) begin
            r_key   <= key_i;
            r_data  <= pt_i;
            r_mode  <= mode_i;
            r_count <= count_i;
            r_gap   <= gap_i;
            r_iter  <= '0;
            r_error <= 1'b0;
        end else if (!w_abort) begin
            if (r_state == LOAD) begin
                r_tmo <= '0;
            end
            if (r_state == WAIT_BUSY) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
            if (r_state == GAP) begin
                r_gapCnt <= r_gapCnt + 1'b1;
            end
            if (w_coreDone) begin
                r_ct     <= aes_data_i;
                r_iter   <= w_iterNext;
                r_gapCnt <= '0;
                case (r_mode)
                    2'd1:    r_data <= aes_data_i;
                    2'd2:    r_data <= r_data + 1'b1;
                    default: r_data <= r_data;
                endcase
            end
        end
    end

    assign aes_key_o  = r_key;
    assign aes_data_o = r_data;
    assign error_o    = r_error;
    assign ct_o       = r_ct;
    assign iter_o     = r_iter;

endmodule

// File: tb/tb_aes_batch_ctrl.sv
// Self-checking bench for aes_batch_ctrl with a behavioural AES-128 core model
// and a plaintext scoreboard checked on every load pulse.
module tb_aes_batch_ctrl;
    localparam int DW  = 128;
    localparam int CW  = 16;
    localparam int GW  = 8;
    localparam int TMO = 64;
    localparam int LAT = 10;

    typedef struct {
        logic [1:0]   mode;
        logic [15:0]  count;
        logic [7:0]   gap;
        logic [127:0] key;
        logic [127:0] pt;
        bit           coreOn;
        logic [15:0]  expIter;
        logic [127:0] expCt;
        bit           expErr;
    } vec_t;

    logic          dut_clk = 1'b0;
    logic          dut_rst = 1'b1;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [1:0]    mode_i  = '0;
    logic [CW-1:0] count_i = '0;
    logic [GW-1:0] gap_i   = '0;
    logic [DW-1:0] key_i   = '0;
    logic [DW-1:0] pt_i    = '0;
    logic          aes_load_o;
    logic [DW-1:0] aes_key_o;
    logic [DW-1:0] aes_data_o;
    logic          aes_busy_i;
    logic [DW-1:0] aes_data_i;
    logic          trigger_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic [DW-1:0] ct_o;
    logic [CW-1:0] iter_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int doneCount = 0;
    int doneBase = 0;
    int lastDoneCyc = 0;
    int errRiseCyc = 0;
    int startCyc = 0;
    bit prevErr = 1'b0;
    bit trigAtErr = 1'b0;
    bit coreOn = 1'b1;
    logic [127:0] curKey = '0;
    logic [127:0] expPtQ[$];
    int loadCycles[$];
    logic [127:0] loadData[$];
    vec_t vecs[7];

    logic         coreBusy;
    logic [7:0]   coreCnt;
    logic [127:0] coreRes;
    logic [127:0] coreData;

    aes_batch_ctrl #(
        .pDATA_WIDTH (DW),
        .pCOUNT_WIDTH(CW),
        .pGAP_WIDTH  (GW),
        .pTIMEOUT    (TMO)
    ) dut (
        .dut_clk   (dut_clk),
        .dut_rst   (dut_rst),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .mode_i    (mode_i),
        .count_i   (count_i),
        .gap_i     (gap_i),
        .key_i     (key_i),
        .pt_i      (pt_i),
        .aes_load_o(aes_load_o),
        .aes_key_o (aes_key_o),
        .aes_data_o(aes_data_o),
        .aes_busy_i(aes_busy_i),
        .aes_data_i(aes_data_i),
        .trigger_o (trigger_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .error_o   (error_o),
        .ct_o      (ct_o),
        .iter_o    (iter_o)
    );

    always #5 dut_clk = ~dut_clk;

    always @(posedge dut_clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("[TB] FAIL watchdog act=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0] s[16];
        logic [7:0] k[16];
        logic [7:0] t[16];
        logic [7:0] rc;
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] w0, w1, w2, w3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox(s[i]);
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[row + 4*c] = t[row + 4*((c + row) % 4)];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                    s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
                end
            end
            w0 = sbox(k[13]) ^ rc; w1 = sbox(k[14]); w2 = sbox(k[15]); w3 = sbox(k[12]);
            k[0] = k[0] ^ w0; k[1] = k[1] ^ w1; k[2] = k[2] ^ w2; k[3] = k[3] ^ w3;
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            rc = xtime(rc);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] nextPt(input logic [1:0] mode, input logic [127:0] p,
                                            input logic [127:0] c);
        case (mode)
            2'd1:    return c;
            2'd2:    return p + 128'd1;
            default: return p;
        endcase
    endfunction

    function automatic logic [127:0] modelBatch(input logic [127:0] key, input logic [127:0] pt,
                                                input logic [1:0] mode, input int count);
        logic [127:0] p;
        logic [127:0] c;
        p = pt;
        c = '0;
        for (int i = 0; i < count; i++) begin
            c = aes128(key, p);
            p = nextPt(mode, p, c);
        end
        return c;
    endfunction

    function automatic vec_t mkVec(input logic [1:0] mode, input logic [15:0] count,
                                   input logic [7:0] gap, input logic [127:0] key,
                                   input logic [127:0] pt, input bit on,
                                   input logic [15:0] expIter, input logic [127:0] expCt,
                                   input bit expErr);
        vec_t v;
        v.mode = mode; v.count = count; v.gap = gap; v.key = key; v.pt = pt;
        v.coreOn = on; v.expIter = expIter; v.expCt = expCt; v.expErr = expErr;
        return v;
    endfunction

    function automatic int expLoads(input vec_t v);
        if (v.coreOn) return int'(v.count);
        return (v.count != 0) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge dut_clk);
        #1;
    endtask

    // Core model: busy for LAT cycles after a load, result valid as busy falls.
    always @(posedge dut_clk) begin
        if (dut_rst) begin
            coreBusy <= 1'b0;
            coreCnt  <= '0;
            coreRes  <= '0;
            coreData <= '0;
        end else if (aes_load_o && coreOn) begin
            coreBusy <= 1'b1;
            coreCnt  <= 8'(LAT - 1);
            coreRes  <= aes128(aes_key_o, aes_data_o);
        end else if (coreBusy) begin
            if (coreCnt == 0) begin
                coreBusy <= 1'b0;
                coreData <= coreRes;
            end else begin
                coreCnt <= coreCnt - 8'd1;
            end
        end
    end
    assign aes_busy_i = coreBusy;
    assign aes_data_i = coreData;

    always @(negedge dut_clk) begin
        if (!dut_rst) begin
            if (aes_load_o) begin
                loadCycles.push_back(cyc);
                loadData.push_back(aes_data_o);
                checkOutput("load_trigger", 128'(trigger_o), 128'(1));
                checkOutput("load_key", aes_key_o, curKey);
                if (expPtQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_load act=%h exp=no_load", aes_data_o);
                end else begin
                    checkOutput("load_pt", aes_data_o, expPtQ.pop_front());
                end
            end
            if (done_o) begin
                doneCount++;
                lastDoneCyc = cyc;
            end
            if (error_o && !prevErr) begin
                errRiseCyc = cyc;
                trigAtErr  = trigger_o;
            end
            prevErr = error_o;
        end else begin
            prevErr = 1'b0;
        end
    end

    task automatic applyStimulus(input vec_t v, input int nLoads);
        logic [127:0] p;
        loadCycles.delete();
        loadData.delete();
        expPtQ.delete();
        curKey = v.key;
        coreOn = v.coreOn;
        p = v.pt;
        for (int i = 0; i < nLoads; i++) begin
            expPtQ.push_back(p);
            p = nextPt(v.mode, p, aes128(v.key, p));
        end
        doneBase = doneCount;
        mode_i   = v.mode;
        count_i  = v.count;
        gap_i    = v.gap;
        key_i    = v.key;
        pt_i     = v.pt;
        start_i  = 1'b1;
        startCyc = cyc;
        tick();
        start_i = 1'b0;
        mode_i  = ~v.mode;
        count_i = v.count + 16'd7;
        gap_i   = v.gap + 8'd3;
        key_i   = {$urandom, $urandom, $urandom, $urandom};
        pt_i    = ~v.pt;
    endtask

    task automatic finishCheck(input vec_t v, input string tag);
        int budget;
        budget = int'(v.count) * (LAT + int'(v.gap) + 4) + TMO + 50;
        for (int i = 0; i < budget && doneCount == doneBase; i++) tick();
        tick();
        checkOutput({tag, "_done_pulses"}, 128'(doneCount - doneBase), 128'(1));
        checkOutput({tag, "_iter"}, 128'(iter_o), 128'(v.expIter));
        checkOutput({tag, "_ct"}, ct_o, v.expCt);
        checkOutput({tag, "_error"}, 128'(error_o), 128'(v.expErr));
        checkOutput({tag, "_busy_after"}, 128'(busy_o), 128'(0));
        checkOutput({tag, "_loads_left"}, 128'(expPtQ.size()), 128'(0));
    endtask

    task automatic waitLoads(input int n, input string tag);
        for (int i = 0; i < 400 && loadCycles.size() < n; i++) tick();
        checkOutput({tag, "_load_seen"}, 128'(loadCycles.size() >= n), 128'(1));
    endtask

    initial begin
        logic [127:0] kF, pF, kB, pB, ctF, ctB;
        vec_t v;
        string tag;
        int n;
        kF  = 128'h000102030405060708090a0b0c0d0e0f;
        pF  = 128'h00112233445566778899aabbccddeeff;
        ctF = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        kB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        pB  = 128'h3243f6a8885a308d313198a2e0370734;
        ctB = 128'h3925841d02dc09fbdc118597196a0b32;

        vecs[0] = mkVec(2'd0, 16'd1, 8'd0, kF, pF, 1'b1, 16'd1, ctF, 1'b0);
        vecs[1] = mkVec(2'd1, 16'd3, 8'd4, kF, pF, 1'b1, 16'd3, modelBatch(kF, pF, 2'd1, 3), 1'b0);
        vecs[2] = mkVec(2'd2, 16'd2, 8'd1, kF, '1, 1'b1, 16'd2, modelBatch(kF, '1, 2'd2, 2), 1'b0);
        vecs[3] = mkVec(2'd3, 16'd2, 8'd2, kB, pB, 1'b1, 16'd2, ctB, 1'b0);
        vecs[4] = mkVec(2'd0, 16'd0, 8'd0, kF, pF, 1'b1, 16'd0, ctB, 1'b0);
        vecs[5] = mkVec(2'd0, 16'd3, 8'd0, kF, pF, 1'b0, 16'd0, ctB, 1'b1);
        vecs[6] = mkVec(2'd0, 16'd1, 8'd0, kF, pF, 1'b1, 16'd1, ctF, 1'b0);

        repeat (3) tick();
        checkOutput("rst_load", 128'(aes_load_o), 128'(0));
        checkOutput("rst_busy", 128'(busy_o), 128'(0));
        checkOutput("rst_done", 128'(done_o), 128'(0));
        checkOutput("rst_trigger", 128'(trigger_o), 128'(0));
        checkOutput("rst_ct", ct_o, '0);
        checkOutput("rst_iter", 128'(iter_o), 128'(0));
        dut_rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            tag = $sformatf("v%0d", i);
            applyStimulus(vecs[i], expLoads(vecs[i]));
            finishCheck(vecs[i], tag);
            if (vecs[i].count != 0 && loadCycles.size() > 0)
                checkOutput({tag, "_start_to_load"}, 128'(loadCycles[0] - startCyc), 128'(1));
            if (vecs[i].count == 0) begin
                checkOutput({tag, "_start_to_done"}, 128'(lastDoneCyc - startCyc), 128'(1));
                checkOutput({tag, "_no_load"}, 128'(loadCycles.size()), 128'(0));
            end else if (vecs[i].coreOn && loadCycles.size() > 0) begin
                for (int j = 1; j < loadCycles.size(); j++)
                    checkOutput({tag, "_load_spacing"}, 128'(loadCycles[j] - loadCycles[j-1]),
                                128'(LAT + 1 + int'(vecs[i].gap) + 1));
                checkOutput({tag, "_last_to_done"},
                            128'(lastDoneCyc - loadCycles[loadCycles.size()-1]), 128'(LAT + 2));
            end else if (loadCycles.size() > 0) begin
                checkOutput({tag, "_err_rise"}, 128'(errRiseCyc - loadCycles[0]), 128'(TMO + 1));
                checkOutput({tag, "_err_done"}, 128'(lastDoneCyc), 128'(errRiseCyc));
                checkOutput({tag, "_err_trigger"}, 128'(trigAtErr), 128'(0));
            end
            if (i == 1 && loadData.size() >= 2)
                checkOutput("chain_second_pt", loadData[1], ctF);
            if (i == 2 && loadData.size() >= 2)
                checkOutput("incr_wrap_pt", loadData[1], '0);
            repeat (5) tick();
        end

        // Abort in the third RUN, then confirm a fresh batch still runs cleanly.
        v = mkVec(2'd0, 16'd5, 8'd2, kB, pB, 1'b1, 16'd0, '0, 1'b0);
        applyStimulus(v, 3);
        waitLoads(3, "abort");
        repeat (3) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        checkOutput("abort_busy", 128'(busy_o), 128'(0));
        checkOutput("abort_trigger", 128'(trigger_o), 128'(0));
        checkOutput("abort_load", 128'(aes_load_o), 128'(0));
        checkOutput("abort_iter", 128'(iter_o), 128'(2));
        checkOutput("abort_ct_hold", ct_o, ctB);
        checkOutput("abort_error", 128'(error_o), 128'(0));
        repeat (40) tick();
        checkOutput("abort_no_done", 128'(doneCount - doneBase), 128'(0));
        checkOutput("abort_loads", 128'(loadCycles.size()), 128'(3));
        v = mkVec(2'd2, 16'd2, 8'd0, kF, pF, 1'b1, 16'd2, modelBatch(kF, pF, 2'd2, 2), 1'b0);
        applyStimulus(v, 2);
        finishCheck(v, "restart");
        repeat (5) tick();

        // A second start mid-batch must not change the running batch.
        v = mkVec(2'd0, 16'd3, 8'd3, kF, pB, 1'b1, 16'd3, aes128(kF, pB), 1'b0);
        applyStimulus(v, 3);
        waitLoads(1, "ignore");
        start_i = 1'b1;
        count_i = 16'd9;
        pt_i    = '0;
        tick();
        start_i = 1'b0;
        finishCheck(v, "ignore");
        checkOutput("ignore_loads", 128'(loadCycles.size()), 128'(3));
        repeat (5) tick();

        loadCycles.delete();
        doneBase = doneCount;
        start_i  = 1'b1;
        abort_i  = 1'b1;
        count_i  = 16'd2;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        repeat (10) tick();
        checkOutput("idle_abort_busy", 128'(busy_o), 128'(0));
        checkOutput("idle_abort_loads", 128'(loadCycles.size()), 128'(0));
        checkOutput("idle_abort_done", 128'(doneCount - doneBase), 128'(0));
        checkOutput("idle_abort_iter", 128'(iter_o), 128'(3));

        v = mkVec(2'd2, 16'd5, 8'd0, kF, pF, 1'b1, 16'd0, '0, 1'b0);
        applyStimulus(v, 5);
        waitLoads(2, "reset");
        repeat (2) tick();
        dut_rst = 1'b1;
        tick();
        checkOutput("midrst_load", 128'(aes_load_o), 128'(0));
        checkOutput("midrst_trigger", 128'(trigger_o), 128'(0));
        checkOutput("midrst_busy", 128'(busy_o), 128'(0));
        checkOutput("midrst_done", 128'(done_o), 128'(0));
        checkOutput("midrst_error", 128'(error_o), 128'(0));
        checkOutput("midrst_ct", ct_o, '0);
        checkOutput("midrst_iter", 128'(iter_o), 128'(0));
        checkOutput("midrst_key", aes_key_o, '0);
        checkOutput("midrst_data", aes_data_o, '0);
        dut_rst  = 1'b0;
        doneBase = doneCount;
        n = loadCycles.size();
        repeat (30) tick();
        checkOutput("midrst_no_done", 128'(doneCount - doneBase), 128'(0));
        checkOutput("midrst_no_load", 128'(loadCycles.size()), 128'(n));
        expPtQ.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
